ttt_game_ctrl: RTL and testbench
================================

// Module: ttt_game_ctrl
// PURPOSE
//  Sits between the PS/2 mouse unit and the VGA painter. Integrates the mouse
//  movement packets into an on-screen cursor and turns left-clicks into moves.
//  Runs the tic-tac-toe game FSM: start screen, play, and result screen.
//  Drives the board contents and the screen enables ceSS/cePS/ceWS to the painter.
// PARAMETERS
//  H_MAX   639  last visible cursor column
//  V_MAX   479  last visible cursor row
//  BX0     170  board left edge, px
//  BY0      90  board top edge, px
//  CELL    100  cell width and height, px (board = 3*CELL square)
// PORTS
//  clk           in   1   system clock, same domain as the mouse unit
//  reset         in   1   synchronous, active-high
//  xm            in   9   mouse X delta, two's complement, valid on m_done_tick
//  ym            in   9   mouse Y delta, two's complement (+ = up), valid on m_done_tick
//  btnm          in   3   mouse buttons {mid,right,left}, valid on m_done_tick
//  m_done_tick   in   1   one-cycle packet-complete strobe from the mouse unit
//  cursor_x      out 10   cursor column, 0..H_MAX
//  cursor_y      out 10   cursor row, 0..V_MAX
//  hover_cell    out  4   cell under cursor 0..8 (row-major), 9 = off board
//  board         out 18   cell i in bits [2i+1:2i]: 00 empty, 01 X, 10 O
//  turn          out  1   0 = X to move, 1 = O to move
//  winner        out  2   00 none, 01 X, 10 O, 11 draw
//  ceSS/cePS/ceWS out 1   start / play / result screen enable, one-hot
//  move_tick     out  1   one-cycle pulse when a mark is placed
// BEHAVIOUR
//  Clock and reset: one clock, synchronous active-high reset.
//  Reset: cursor = (320,240), board = 0, turn = 0, winner = 00, prev_left = 0,
//   state START (ceSS=1, cePS=0, ceWS=0), move_tick = 0.
//  Cursor: updated only on m_done_tick. x' = x + sxt(xm); y' = y - sxt(ym).
//   Compute in 11-bit signed; clamp to 0..H_MAX / 0..V_MAX. No wrap-around.
//  Click: left_press = m_done_tick & btnm[0] & ~prev_left.
//   prev_left <= btnm[0] only on m_done_tick. Holding the button never re-triggers.
//  A click uses the cursor value held before the same packet's movement applies.
//  hover_cell: combinational from cursor_x and cursor_y using compares against
//   BX0 + k*CELL (no divider). Edge pixels belong to the lower-index cell.
//  FSM, one state register:
//   START: left_press -> PLAY. On entry: board cleared, turn = 0, winner = 00.
//   PLAY: left_press with hover_cell < 9 and that cell empty -> write mark(turn),
//    pulse move_tick, go to CHECK. Clicks off the board or on an occupied cell
//    are ignored.
//   CHECK (1 cycle): evaluate the 8 lines. Win -> winner = owner, go to RESULT.
//    Else board full -> winner = 11, go to RESULT. Else toggle turn, go to PLAY.
//    Clicks arriving during CHECK are dropped.
//   RESULT: board frozen; left_press -> START.
//  Screen enables are registered from state: CHECK reports cePS=1. Exactly one
//   enable is high in every cycle.
//  Latency: click to board update takes 1 cycle; click to winner/turn takes 2 cycles.
//  Reset mid-game: returns to START within 1 cycle; any partial move is discarded.
//  Right and middle buttons are ignored.
// STRUCTURE
//  Package ttt_pkg: cell codes EMPTY/X/O, winner codes, FSM state encodings,
//   and the 8-entry win-line table of cell-index triples.
//  Sub-module ttt_win_check: combinational, board[17:0] -> {win_x, win_o, full}.
//   It is shared with any future AI player.
// TESTING
//  1. Reset, then a packet xm=+50, ym=+20 -> cursor = (370,220); ceSS=1.
//  2. Packet xm=-256 repeated 3x from x=320 -> cursor_x clamps at 0, no wrap;
//     ym=-256 x2 -> y = 479.
//  3. Click in START -> cePS=1, board=0. Click at (220,140) -> board[1:0]=01,
//     move_tick for 1 cycle, turn=1 two cycles later.
//  4. Click again on cell 0, then at (5,5) -> board unchanged, turn stays 1.
//     Hold btnm[0]=1 over 4 packets -> exactly 1 move.
//  5. X plays cells 0, 1, 2 (O plays 3, 4) -> winner=01, ceWS=1. Click -> ceSS=1.
//     Draw sequence 0,1,2,4,3,5,7,6,8 -> winner=11.
//  6. Assert reset in the cycle after move_tick (state CHECK) -> next cycle
//     ceSS=1, board=0, winner=00.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe game controller:
// screen geometry, cell/winner codes, FSM states and the win-line table.
package ttt_pkg;

    localparam int H_MAX = 639;
    localparam int V_MAX = 479;
    localparam int BX0   = 170;
    localparam int BY0   = 90;
    localparam int CELL  = 100;

    localparam logic [9:0] CUR_X0 = 10'd320;
    localparam logic [9:0] CUR_Y0 = 10'd240;
    localparam logic [3:0] OFF_BOARD = 4'd9;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_X     = 2'b01,
        CELL_O     = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_X    = 2'b01,
        WIN_O    = 2'b10,
        WIN_DRAW = 2'b11
    } winner_t;

    typedef enum logic [1:0] {
        S_START  = 2'd0,
        S_PLAY   = 2'd1,
        S_CHECK  = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    // Rows, columns, then the two diagonals.
    localparam logic [0:7][0:2][3:0] WIN_LINES = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    // Column/row index along one axis, 3 = off the board.
    // A pixel on a shared edge goes to the lower-index cell.
    function automatic logic [1:0] axis_cell(
        input logic [9:0] p,
        input logic [9:0] base
    );
        logic [10:0] v;
        logic [10:0] b;
        v = {1'b0, p};
        b = {1'b0, base};
        if (v < b)
            axis_cell = 2'd3;
        else if (v <= b + 11'(CELL))
            axis_cell = 2'd0;
        else if (v <= b + 11'(2 * CELL))
            axis_cell = 2'd1;
        else if (v <= b + 11'(3 * CELL))
            axis_cell = 2'd2;
        else
            axis_cell = 2'd3;
    endfunction

endpackage

// File: rtl/ttt_win_check.sv
// Combinational board evaluator: reports a completed line for
// either player and whether every cell is occupied.
module ttt_win_check
    import ttt_pkg::*;
(
    input  logic [17:0] i_board,
    output logic        o_win_x,
    output logic        o_win_o,
    output logic        o_full
);

    logic [1:0] w_a;
    logic [1:0] w_b;
    logic [1:0] w_c;

    always_comb begin
        o_win_x = 1'b0;
        o_win_o = 1'b0;
        o_full  = 1'b1;
        w_a     = 2'b00;
        w_b     = 2'b00;
        w_c     = 2'b00;
        for (int l = 0; l < 8; l++) begin
            w_a = i_board[2 * int'(WIN_LINES[l][0]) +: 2];
            w_b = i_board[2 * int'(WIN_LINES[l][1]) +: 2];
            w_c = i_board[2 * int'(WIN_LINES[l][2]) +: 2];
            if (w_a == CELL_X && w_b == CELL_X && w_c == CELL_X)
                o_win_x = 1'b1;
            if (w_a == CELL_O && w_b == CELL_O && w_c == CELL_O)
                o_win_o = 1'b1;
        end
        for (int i = 0; i < 9; i++) begin
            if (i_board[2 * i +: 2] == CELL_EMPTY)
                o_full = 1'b0;
        end
    end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe controller: integrates mouse packets into a cursor,
// turns left clicks into moves and sequences start/play/result screens.
module ttt_game_ctrl
    import ttt_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [8:0]  xm,
    input  logic [8:0]  ym,
    input  logic [2:0]  btnm,
    input  logic        m_done_tick,
    output logic [9:0]  cursor_x,
    output logic [9:0]  cursor_y,
    output logic [3:0]  hover_cell,
    output logic [17:0] board,
    output logic        turn,
    output logic [1:0]  winner,
    output logic        ceSS,
    output logic        cePS,
    output logic        ceWS,
    output logic        move_tick
);

    logic [9:0]  r_cx;
    logic [9:0]  r_cy;
    logic        r_prev_left;
    state_t      r_state;
    logic [17:0] r_board;
    logic        r_turn;
    logic [1:0]  r_winner;
    logic        r_move_tick;
    logic        r_ss;
    logic        r_ps;
    logic        r_ws;

    logic signed [10:0] w_nx;
    logic signed [10:0] w_ny;
    logic [9:0]  w_cx_clamp;
    logic [9:0]  w_cy_clamp;
    logic        w_left_press;
    logic [1:0]  w_col;
    logic [1:0]  w_row;
    logic [3:0]  w_hover;
    logic        w_cell_free;
    logic        w_win_x;
    logic        w_win_o;
    logic        w_full;
    state_t      w_state_nxt;
    logic [17:0] w_board_nxt;
    logic        w_turn_nxt;
    logic [1:0]  w_winner_nxt;
    logic        w_tick_nxt;
    logic        w_unused_btn;

    assign w_unused_btn = &{1'b0, btnm[2:1]};

    // Movement in 11-bit signed so over/underflow is visible before clamping.
    assign w_nx = $signed({1'b0, r_cx}) + $signed({{2{xm[8]}}, xm});
    assign w_ny = $signed({1'b0, r_cy}) - $signed({{2{ym[8]}}, ym});

    always_comb begin
        w_cx_clamp = w_nx[9:0];
        if (w_nx < 0)
            w_cx_clamp = 10'd0;
        else if (w_nx > 11'sd639)
            w_cx_clamp = 10'(H_MAX);
        w_cy_clamp = w_ny[9:0];
        if (w_ny < 0)
            w_cy_clamp = 10'd0;
        else if (w_ny > 11'sd479)
            w_cy_clamp = 10'(V_MAX);
    end

    assign w_left_press = m_done_tick & btnm[0] & ~r_prev_left;

    assign w_col = axis_cell(r_cx, 10'(BX0));
    assign w_row = axis_cell(r_cy, 10'(BY0));

    always_comb begin
        w_hover = OFF_BOARD;
        if (w_col != 2'd3 && w_row != 2'd3)
            w_hover = {2'b00, w_row} * 4'd3 + {2'b00, w_col};
    end

    always_comb begin
        w_cell_free = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (w_hover == 4'(i) && r_board[2 * i +: 2] == CELL_EMPTY)
                w_cell_free = 1'b1;
        end
    end

    ttt_win_check u_win_check (
        .i_board (r_board),
        .o_win_x (w_win_x),
        .o_win_o (w_win_o),
        .o_full  (w_full)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_board_nxt  = r_board;
        w_turn_nxt   = r_turn;
        w_winner_nxt = r_winner;
        w_tick_nxt   = 1'b0;
        unique case (r_state)
            S_START: begin
                if (w_left_press) begin
                    w_state_nxt  = S_PLAY;
                    w_board_nxt  = '0;
                    w_turn_nxt   = 1'b0;
                    w_winner_nxt = WIN_NONE;
                end
            end
            S_PLAY: begin
                if (w_left_press && w_cell_free) begin
                    w_board_nxt[{w_hover, 1'b0} +: 2] =
                        r_turn ? CELL_O : CELL_X;
                    w_tick_nxt  = 1'b1;
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_win_x) begin
                    w_winner_nxt = WIN_X;
                    w_state_nxt  = S_RESULT;
                end else if (w_win_o) begin
                    w_winner_nxt = WIN_O;
                    w_state_nxt  = S_RESULT;
                end else if (w_full) begin
                    w_winner_nxt = WIN_DRAW;
                    w_state_nxt  = S_RESULT;
                end else begin
                    w_turn_nxt  = ~r_turn;
                    w_state_nxt = S_PLAY;
                end
            end
            S_RESULT: begin
                if (w_left_press) begin
                    w_state_nxt  = S_START;
                    w_board_nxt  = '0;
                    w_turn_nxt   = 1'b0;
                    w_winner_nxt = WIN_NONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_START;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cx        <= CUR_X0;
            r_cy        <= CUR_Y0;
            r_prev_left <= 1'b0;
            r_board     <= '0;
            r_turn      <= 1'b0;
            r_winner    <= WIN_NONE;
            r_move_tick <= 1'b0;
            r_ss        <= 1'b1;
            r_ps        <= 1'b0;
            r_ws        <= 1'b0;
        end else begin
            if (m_done_tick) begin
                r_cx        <= w_cx_clamp;
                r_cy        <= w_cy_clamp;
                r_prev_left <= btnm[0];
            end
            r_board     <= w_board_nxt;
            r_turn      <= w_turn_nxt;
            r_winner    <= w_winner_nxt;
            r_move_tick <= w_tick_nxt;
            // Enables track the state register exactly; CHECK stays on the play screen.
            r_ss        <= (w_state_nxt == S_START);
            r_ps        <= (w_state_nxt == S_PLAY) || (w_state_nxt == S_CHECK);
            r_ws        <= (w_state_nxt == S_RESULT);
        end
    end

    assign cursor_x   = r_cx;
    assign cursor_y   = r_cy;
    assign hover_cell = w_hover;
    assign board      = r_board;
    assign turn       = r_turn;
    assign winner     = r_winner;
    assign ceSS       = r_ss;
    assign cePS       = r_ps;
    assign ceWS       = r_ws;
    assign move_tick  = r_move_tick;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Bench for ttt_game_ctrl: directed scenarios plus random mouse traffic,
// all compared every cycle against a behavioural game model.
module tb_ttt_game_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [8:0]  xm = '0;
    logic [8:0]  ym = '0;
    logic [2:0]  btnm = '0;
    logic        m_done_tick = 1'b0;
    logic [9:0]  cursor_x;
    logic [9:0]  cursor_y;
    logic [3:0]  hover_cell;
    logic [17:0] board;
    logic        turn;
    logic [1:0]  winner;
    logic        ceSS;
    logic        cePS;
    logic        ceWS;
    logic        move_tick;

    always #5 clk = ~clk;

    ttt_game_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .xm          (xm),
        .ym          (ym),
        .btnm        (btnm),
        .m_done_tick (m_done_tick),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .hover_cell  (hover_cell),
        .board       (board),
        .turn        (turn),
        .winner      (winner),
        .ceSS        (ceSS),
        .cePS        (cePS),
        .ceWS        (ceWS),
        .move_tick   (move_tick)
    );

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;
    int dut_ticks = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: screen 0=start 1=play 2=play(evaluating) 3=result.
    int mx, my, mturn, mwin, mscr;
    int cells[9];
    bit mprev, mtick;

    function automatic int axis(int p, int b);
        if (p < b || p > b + 300) return -1;
        if (p == b) return 0;
        return (p - b - 1) / 100;
    endfunction

    function automatic int hov(int x, int y);
        int c, r;
        c = axis(x, 170);
        r = axis(y, 90);
        if (c < 0 || r < 0) return 9;
        return r * 3 + c;
    endfunction

    function automatic int same3(int a, int b, int c);
        if (cells[a] != 0 && cells[a] == cells[b] && cells[b] == cells[c])
            return cells[a];
        return 0;
    endfunction

    function automatic int owner();
        int w;
        w = 0;
        for (int k = 0; k < 3; k++) begin
            if (same3(3 * k, 3 * k + 1, 3 * k + 2) != 0) w = same3(3 * k, 3 * k + 1, 3 * k + 2);
            if (same3(k, k + 3, k + 6) != 0) w = same3(k, k + 3, k + 6);
        end
        if (same3(0, 4, 8) != 0) w = same3(0, 4, 8);
        if (same3(2, 4, 6) != 0) w = same3(2, 4, 6);
        return w;
    endfunction

    function automatic int clampi(int v, int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic bit all_full();
        for (int i = 0; i < 9; i++) if (cells[i] == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [17:0] packed_board();
        logic [17:0] b;
        b = '0;
        for (int i = 0; i < 9; i++) b = b | (18'(cells[i]) << (2 * i));
        return b;
    endfunction

    task automatic clear_game();
        for (int i = 0; i < 9; i++) cells[i] = 0;
        mturn = 0;
        mwin = 0;
    endtask

    task automatic model_step();
        bit lp;
        int hc, w;
        if (reset) begin
            mx = 320; my = 240; clear_game();
            mscr = 0; mprev = 1'b0; mtick = 1'b0;
            return;
        end
        lp = m_done_tick && btnm[0] && !mprev;
        hc = hov(mx, my);
        mtick = 1'b0;
        case (mscr)
            0: if (lp) begin clear_game(); mscr = 1; end
            1: if (lp && hc < 9 && cells[hc] == 0) begin
                cells[hc] = mturn + 1; mtick = 1'b1; mscr = 2;
            end
            2: begin
                w = owner();
                if (w != 0) begin mwin = w; mscr = 3; end
                else if (all_full()) begin mwin = 3; mscr = 3; end
                else begin mturn = 1 - mturn; mscr = 1; end
            end
            default: if (lp) begin clear_game(); mscr = 0; end
        endcase
        if (m_done_tick) begin
            mx = clampi(mx + int'($signed(xm)), 639);
            my = clampi(my - int'($signed(ym)), 479);
            mprev = btnm[0];
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cursor_x", 32'(cursor_x), 32'(mx));
            chk("cursor_y", 32'(cursor_y), 32'(my));
            chk("hover_cell", 32'(hover_cell), 32'(hov(mx, my)));
            chk("board", 32'(board), 32'(packed_board()));
            chk("turn", 32'(turn), 32'(mturn));
            chk("winner", 32'(winner), 32'(mwin));
            chk("ceSS", 32'(ceSS), 32'(mscr == 0));
            chk("cePS", 32'(cePS), 32'(mscr == 1 || mscr == 2));
            chk("ceWS", 32'(ceWS), 32'(mscr == 3));
            chk("move_tick", 32'(move_tick), 32'(mtick));
            if (move_tick === 1'b1) dut_ticks++;
        end
    end

    // One packet; right/middle buttons and idle-bus data are random noise.
    task automatic send(input int dx, input int dy, input bit left);
        @(negedge clk);
        xm = 9'(dx);
        ym = 9'(dy);
        btnm = {2'($urandom_range(0, 3)), left};
        m_done_tick = 1'b1;
        @(negedge clk);
        m_done_tick = 1'b0;
        xm = 9'($urandom);
        ym = 9'($urandom);
        btnm = 3'($urandom);
    endtask

    task automatic goto_xy(input int tx, input int ty);
        int dx, dy;
        for (int n = 0; n < 8 && (mx != tx || my != ty); n++) begin
            dx = tx - mx;
            dy = my - ty;
            if (dx > 255) dx = 255;
            if (dx < -255) dx = -255;
            if (dy > 255) dy = 255;
            if (dy < -255) dy = -255;
            send(dx, dy, 1'b0);
        end
    endtask

    task automatic click_at(input int tx, input int ty);
        goto_xy(tx, ty);
        send(0, 0, 1'b1);
        send(0, 0, 1'b0);
    endtask

    task automatic click_cell(input int k);
        click_at(220 + 100 * (k % 3), 140 + 100 * (k / 3));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    int t0;
    int seq_win[5] = '{0, 3, 1, 4, 2};
    int seq_draw[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cmp_en = 1'b1;
        chk("rst_cx", 32'(cursor_x), 32'd320);
        chk("rst_cy", 32'(cursor_y), 32'd240);
        chk("rst_ss", 32'({ceSS, cePS, ceWS}), 32'b100);
        chk("rst_board", 32'(board), 32'd0);

        send(50, 20, 1'b0);
        chk("t1_cx", 32'(cursor_x), 32'd370);
        chk("t1_cy", 32'(cursor_y), 32'd220);
        chk("t1_ss", 32'(ceSS), 32'd1);

        do_reset();
        repeat (3) send(-256, 0, 1'b0);
        chk("t2_cx_clamp", 32'(cursor_x), 32'd0);
        repeat (2) send(0, -256, 1'b0);
        chk("t2_cy_clamp", 32'(cursor_y), 32'd479);

        do_reset();
        send(0, 0, 1'b1);
        send(0, 0, 1'b0);
        chk("t3_ps", 32'(cePS), 32'd1);
        chk("t3_board0", 32'(board), 32'd0);
        goto_xy(220, 140);
        send(0, 0, 1'b1);
        chk("t3_mark", 32'(board[1:0]), 32'd1);
        chk("t3_tick", 32'(move_tick), 32'd1);
        chk("t3_turn_early", 32'(turn), 32'd0);
        @(negedge clk);
        chk("t3_tick_off", 32'(move_tick), 32'd0);
        chk("t3_turn", 32'(turn), 32'd1);
        send(0, 0, 1'b0);

        click_at(220, 140);
        click_at(5, 5);
        chk("t4_board", 32'(board), 32'd1);
        chk("t4_turn", 32'(turn), 32'd1);
        goto_xy(320, 240);
        t0 = dut_ticks;
        repeat (4) send(0, 0, 1'b1);
        send(0, 0, 1'b0);
        chk("t4_hold_moves", 32'(dut_ticks - t0), 32'd1);

        do_reset();
        click_at(10, 10);
        foreach (seq_win[i]) click_cell(seq_win[i]);
        chk("t5_win", 32'(winner), 32'd1);
        chk("t5_ws", 32'(ceWS), 32'd1);
        click_at(10, 10);
        chk("t5_ss", 32'(ceSS), 32'd1);
        chk("t5_clear", 32'(board), 32'd0);
        click_at(10, 10);
        foreach (seq_draw[i]) click_cell(seq_draw[i]);
        chk("t5_draw", 32'(winner), 32'd3);
        chk("t5_draw_ws", 32'(ceWS), 32'd1);

        do_reset();
        click_at(10, 10);
        goto_xy(220, 140);
        send(0, 0, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t6_ss", 32'(ceSS), 32'd1);
        chk("t6_board", 32'(board), 32'd0);
        chk("t6_winner", 32'(winner), 32'd0);

        for (int it = 0; it < 400; it++) begin
            int r;
            r = $urandom_range(0, 29);
            if (r == 0) begin
                do_reset();
            end else if (r < 14) begin
                click_at($urandom_range(150, 490), $urandom_range(70, 410));
            end else if (r < 17) begin
                click_cell($urandom_range(0, 8));
            end else begin
                send($urandom_range(0, 511) - 256, $urandom_range(0, 511) - 256,
                     1'($urandom));
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
